// File: rtl/sprite_rom_scheduler_if.sv
// sprite_rom_scheduler_if
//   Configuration write channel of the sprite ROM scheduler. A write is
//   transferred on a cycle where cfg_valid_in and cfg_ready_out are both high.
//   master : the config source (CPU / register block)
//   slave  : sprite_rom_scheduler
// Signals:
//   cfg_valid_in   a config write is offered
//   cfg_ready_out  a config write can be accepted
//   cfg_idx_in     slot being written
//   cfg_x_in       sprite left edge
//   cfg_y_in       sprite top edge
//   cfg_glyph_in   glyph number in the ROM
//   cfg_en_in      slot enable
interface sprite_rom_scheduler_if #(
  parameter int NUM_SPRITES = 4
);
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic             cfg_valid_in;
  logic             cfg_ready_out;
  logic [IDX_W-1:0] cfg_idx_in;
  logic [10:0]      cfg_x_in;
  logic [9:0]       cfg_y_in;
  logic [3:0]       cfg_glyph_in;
  logic             cfg_en_in;

  modport master (
    output cfg_valid_in, cfg_idx_in, cfg_x_in, cfg_y_in, cfg_glyph_in, cfg_en_in,
    input  cfg_ready_out
  );

  modport slave (
    input  cfg_valid_in, cfg_idx_in, cfg_x_in, cfg_y_in, cfg_glyph_in, cfg_en_in,
    output cfg_ready_out
  );
endinterface

// File: rtl/sprite_rom_scheduler.sv
// sprite_rom_scheduler
//   Shares one glyph ROM between NUM_SPRITES sprite slots. For each pixel the
//   lowest-index enabled slot covering it wins, the shared ROM address is
//   formed, and the returned byte is turned into a 12-bit grey pixel that is
//   aligned with a delayed hit flag. Pixel latency is 2+ROM_LATENCY cycles.
//   Slot configuration is double-buffered: writes land in shadow registers and
//   are copied to the active set in the commit cycle (hcount_in==0 &&
//   vcount_in==0).
// Optional feature macro: SPRITE_COLLISION_EN adds the sticky collision_out.
// Ports:
//   pixel_clk_in   pixel clock (only clock)
//   rst_in         synchronous active-high reset
//   hcount_in      pixel column, vcount_in pixel row
//   cfg            config write channel (sprite_rom_scheduler_if.slave)
//   rom_addr_out   shared ROM address, rom_data_in ROM byte
//   hit_out        pixel_out comes from a sprite
//   pixel_out      {d[7:4],d[7:4],d[7:4]} or 0
//   collision_out  sticky overlap flag (SPRITE_COLLISION_EN only)
// Parameters H_TOTAL/V_TOTAL give the raster size; cfg_ready_out is a
// register, so its drop in the commit cycle is prepared on the last pixel of
// the frame (H_TOTAL-1, V_TOTAL-1). Acceptance itself is also gated by the
// live commit condition, so a write is never taken in the commit cycle.
module sprite_rom_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int WIDTH       = 16,
  parameter int HEIGHT      = 16,
  parameter int ROM_LATENCY = 2,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  sprite_rom_scheduler_if.slave cfg,
  output logic [15:0] rom_addr_out,
  input  logic [7:0]  rom_data_in,
  output logic        hit_out,
  output logic [11:0] pixel_out
`ifdef SPRITE_COLLISION_EN
  ,
  output logic        collision_out
`endif
);
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  typedef struct packed {
    logic        en;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  glyph;
  } slot_t;

  slot_t                  act_r [NUM_SPRITES];
  slot_t                  shd_r [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] pending_r;
  logic                   ready_r;
  logic [15:0]            rom_addr_r;
  logic [ROM_LATENCY:0]   hit_pipe_r;
  logic                   hit_r;
  logic [11:0]            pixel_r;

  logic                   commit_s;
  logic                   pre_commit_s;
  logic                   accept_s;
  logic [NUM_SPRITES-1:0] hit_vec_s;
  logic                   any_hit_s;
  logic [IDX_W-1:0]       win_s;
  slot_t                  sel_s;
  logic [15:0]            addr_s;
  logic                   unused_rom_bits_s;

  assign commit_s     = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign pre_commit_s = (hcount_in == 11'(H_TOTAL - 1)) && (vcount_in == 10'(V_TOTAL - 1));
  assign accept_s     = cfg.cfg_valid_in && ready_r && !commit_s;
  // Low nibble of the ROM byte carries no displayed information.
  assign unused_rom_bits_s = ^rom_data_in[3:0];

  // Ready register: low during reset and in the commit cycle.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= !pre_commit_s;
    end
  end

  // Shadow writes on handshake, shadow-to-active copy in the commit cycle.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_r[i] <= '0;
        shd_r[i] <= '0;
      end
      pending_r <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (commit_s && pending_r[i]) begin
          act_r[i]     <= shd_r[i];
          pending_r[i] <= 1'b0;
        end else if (accept_s && (cfg.cfg_idx_in == IDX_W'(i))) begin
          shd_r[i]     <= {cfg.cfg_en_in, cfg.cfg_x_in, cfg.cfg_y_in, cfg.cfg_glyph_in};
          pending_r[i] <= 1'b1;
        end
      end
    end
  end

  // Per-slot hit test; 12-bit compares keep an overflowing edge from wrapping.
  always_comb begin
    hit_vec_s = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit_vec_s[i] = act_r[i].en
                  && ({1'b0, hcount_in} >= {1'b0, act_r[i].x})
                  && ({1'b0, hcount_in} <  ({1'b0, act_r[i].x} + 12'(WIDTH)))
                  && ({2'b00, vcount_in} >= {2'b00, act_r[i].y})
                  && ({2'b00, vcount_in} <  ({2'b00, act_r[i].y} + 12'(HEIGHT)));
    end
  end

  // Priority select: scanning downward leaves the lowest hitting index.
  always_comb begin
    win_s = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      win_s = hit_vec_s[i] ? IDX_W'(i) : win_s;
    end
  end

  assign any_hit_s = |hit_vec_s;
  assign sel_s     = act_r[win_s];
  assign addr_s    = 16'(sel_s.glyph) * 16'(WIDTH * HEIGHT)
                   + 16'(vcount_in - sel_s.y) * 16'(WIDTH)
                   + 16'(hcount_in - sel_s.x);

  // S0: ROM address (held on miss) and the hit delay line.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rom_addr_r <= 16'd0;
      hit_pipe_r <= '0;
    end else begin
      if (any_hit_s) begin
        rom_addr_r <= addr_s;
      end
      hit_pipe_r <= {hit_pipe_r[ROM_LATENCY-1:0], any_hit_s};
    end
  end

  // Output stage: pair the returned byte with its delayed hit flag.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hit_r   <= 1'b0;
      pixel_r <= 12'd0;
    end else begin
      hit_r   <= hit_pipe_r[ROM_LATENCY];
      pixel_r <= hit_pipe_r[ROM_LATENCY] ? {3{rom_data_in[7:4]}} : 12'd0;
    end
  end

  assign cfg.cfg_ready_out = ready_r;
  assign rom_addr_out      = rom_addr_r;
  assign hit_out           = hit_r;
  assign pixel_out         = pixel_r;

`ifdef SPRITE_COLLISION_EN
  logic                 coll_s0_s;
  logic [ROM_LATENCY:0] coll_pipe_r;
  logic                 collision_r;

  // More than one bit set in the hit vector means overlapping sprites.
  assign coll_s0_s = (hit_vec_s & (hit_vec_s - NUM_SPRITES'(1))) != '0;

  // Collision delay line and sticky flag; a new hit outranks the commit clear.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      coll_pipe_r <= '0;
      collision_r <= 1'b0;
    end else begin
      coll_pipe_r <= {coll_pipe_r[ROM_LATENCY-1:0], coll_s0_s};
      if (coll_pipe_r[ROM_LATENCY]) begin
        collision_r <= 1'b1;
      end else if (commit_s) begin
        collision_r <= 1'b0;
      end
    end
  end

  assign collision_out = collision_r;
`endif

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// tb_sprite_rom_scheduler
//   Self-checking bench for sprite_rom_scheduler. A behavioural model of the
//   slot registers predicts, for every driven pixel, the ROM address and the
//   pixel/hit (and collision) that must appear 4 cycles later; those
//   predictions are queued and popped as the DUT outputs them. Uses a small
//   64x32 raster so a whole frame scan stays short.
module tb_sprite_rom_scheduler;
  localparam int H_TOT = 64;
  localparam int V_TOT = 32;
  localparam int LAT   = 2;

  typedef struct packed {
    logic        en;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  g;
  } slot_t;

  typedef struct packed {
    logic        hit;
    logic [11:0] pix;
    logic        coll;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hc  = 11'd0;
  logic [9:0]  vc  = 10'd0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        hit;
  logic [11:0] pix;
`ifdef SPRITE_COLLISION_EN
  logic        coll;
  logic        m_coll;
`endif

  sprite_rom_scheduler_if #(.NUM_SPRITES(4)) cfg_bus ();

  sprite_rom_scheduler #(
    .NUM_SPRITES(4), .WIDTH(16), .HEIGHT(16), .ROM_LATENCY(LAT),
    .H_TOTAL(H_TOT), .V_TOTAL(V_TOT)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .hcount_in    (hc),
    .vcount_in    (vc),
    .cfg          (cfg_bus),
    .rom_addr_out (rom_addr),
    .rom_data_in  (rom_data),
    .hit_out      (hit),
    .pixel_out    (pix)
`ifdef SPRITE_COLLISION_EN
    ,
    .collision_out(coll)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA6;
  endfunction

  // ROM model: address registered LAT times, byte formed from the last stage.
  logic [15:0] rq [LAT];
  always @(posedge clk) begin
    rq[0] <= rom_addr;
    for (int k = 1; k < LAT; k++) rq[k] <= rq[k-1];
  end
  assign rom_data = rom_byte(rq[LAT-1]);

  slot_t       m_act [4];
  slot_t       m_shd [4];
  logic [3:0]  m_pend;
  logic [15:0] m_addr;
  logic        first_after_rst;
  exp_t        q [$];
  int          n_vec = 0;
  int          n_err = 0;

  // One pixel cycle: drive, predict, clock, compare address and popped output.
  task automatic step(input logic [10:0] h, input logic [9:0] v);
    exp_t       e;
    int         w;
    int         nhit;
    logic       commit;
    logic       exp_rdy;
    logic [7:0] b;
    hc = h;
    vc = v;
    commit  = (h == 11'd0) && (v == 10'd0);
    exp_rdy = !first_after_rst && !commit;
    n_vec++;
    if (cfg_bus.cfg_ready_out !== exp_rdy) begin
      n_err++;
      $display("FAIL ready at (%0d,%0d): got %b want %b", h, v, cfg_bus.cfg_ready_out, exp_rdy);
    end
    w = -1;
    nhit = 0;
    for (int i = 3; i >= 0; i--) begin
      if (m_act[i].en && int'(h) >= int'(m_act[i].x) && int'(h) < int'(m_act[i].x) + 16
          && int'(v) >= int'(m_act[i].y) && int'(v) < int'(m_act[i].y) + 16) begin
        w = i;
        nhit++;
      end
    end
    if (w >= 0)
      m_addr = 16'(int'(m_act[w].g) * 256 + (int'(v) - int'(m_act[w].y)) * 16
                    + (int'(h) - int'(m_act[w].x)));
    b = rom_byte(m_addr);
    e.hit  = (w >= 0);
    e.pix  = e.hit ? {b[7:4], b[7:4], b[7:4]} : 12'd0;
    e.coll = (nhit >= 2);
    q.push_back(e);
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i]) begin
          m_act[i]  = m_shd[i];
          m_pend[i] = 1'b0;
        end
      end
    end
    if (cfg_bus.cfg_valid_in && exp_rdy) begin
      m_shd[cfg_bus.cfg_idx_in]  = {cfg_bus.cfg_en_in, cfg_bus.cfg_x_in, cfg_bus.cfg_y_in, cfg_bus.cfg_glyph_in};
      m_pend[cfg_bus.cfg_idx_in] = 1'b1;
    end
    @(posedge clk);
    #1;
    first_after_rst = 1'b0;
    n_vec++;
    if (rom_addr !== m_addr) begin
      n_err++;
      $display("FAIL rom_addr after (%0d,%0d): got %0d want %0d", h, v, rom_addr, m_addr);
    end
    if (q.size() >= 4) begin
      e = q.pop_front();
      n_vec++;
      if (hit !== e.hit || pix !== e.pix) begin
        n_err++;
        $display("FAIL pixel at (%0d,%0d): got hit=%b pix=%h want hit=%b pix=%h", h, v, hit, pix, e.hit, e.pix);
      end
`ifdef SPRITE_COLLISION_EN
      m_coll = e.coll ? 1'b1 : (commit ? 1'b0 : m_coll);
      n_vec++;
      if (coll !== m_coll) begin
        n_err++;
        $display("FAIL collision at (%0d,%0d): got %b want %b", h, v, coll, m_coll);
      end
`endif
    end
  endtask

  task automatic commit_frame();
    step(11'(H_TOT - 1), 10'(V_TOT - 1));
    step(11'd0, 10'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(11'd10, 10'd10);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [10:0] x, input logic [9:0] y,
                           input logic [3:0] g, input logic en,
                           input logic [10:0] h, input logic [9:0] v);
    cfg_bus.cfg_idx_in   = idx;
    cfg_bus.cfg_x_in     = x;
    cfg_bus.cfg_y_in     = y;
    cfg_bus.cfg_glyph_in = g;
    cfg_bus.cfg_en_in    = en;
    cfg_bus.cfg_valid_in = 1'b1;
    step(h, v);
    cfg_bus.cfg_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (rom_addr !== 16'd0 || hit !== 1'b0 || pix !== 12'd0 || cfg_bus.cfg_ready_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%0d hit=%b pix=%h rdy=%b want 0 0 000 0",
               rom_addr, hit, pix, cfg_bus.cfg_ready_out);
    end
`ifdef SPRITE_COLLISION_EN
    n_vec++;
    if (coll !== 1'b0) begin
      n_err++;
      $display("FAIL reset_collision: got %b want 0", coll);
    end
    m_coll = 1'b0;
`endif
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = '0;
      m_shd[i] = '0;
    end
    m_pend = 4'd0;
    m_addr = 16'd0;
    first_after_rst = 1'b1;
    q.delete();
    repeat (3) q.push_back(exp_t'(0));
  endtask

  task automatic test_blank_frame();
    step(11'(H_TOT - 1), 10'(V_TOT - 1));
    for (int v = 0; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++) step(11'(h), 10'(v));
    step(11'd0, 10'd0);
    idle(4);
  endtask

  task automatic test_single_sprite();
    cfg_write(2'd0, 11'd100, 10'd50, 4'd5, 1'b1, 11'd30, 10'd10);
    step(11'd100, 10'd50);
    idle(3);
    n_vec++;
    if (hit !== 1'b0) begin
      n_err++;
      $display("FAIL uncommitted_hit: got %b want 0", hit);
    end
    commit_frame();
    step(11'd100, 10'd50);
    n_vec++;
    if (rom_addr !== 16'd1280) begin
      n_err++;
      $display("FAIL first_addr: got %0d want 1280", rom_addr);
    end
    idle(3);
    n_vec++;
    if (pix !== 12'hAAA || hit !== 1'b1) begin
      n_err++;
      $display("FAIL first_pixel: got hit=%b pix=%h want 1 AAA", hit, pix);
    end
    step(11'd101, 10'd50);
    step(11'd115, 10'd65);
    step(11'd116, 10'd50);
    step(11'd99, 10'd50);
    step(11'd100, 10'd66);
    idle(4);
  endtask

  task automatic test_overlap();
    cfg_write(2'd0, 11'd195, 10'd75, 4'd2, 1'b1, 11'd20, 10'd5);
    cfg_write(2'd1, 11'd200, 10'd80, 4'd7, 1'b1, 11'd21, 10'd5);
    commit_frame();
    idle(3);
    step(11'd200, 10'd80);
    n_vec++;
    if (rom_addr !== 16'd597) begin
      n_err++;
      $display("FAIL overlap_addr: got %0d want 597", rom_addr);
    end
    idle(3);
    n_vec++;
    if (pix !== 12'hFFF || hit !== 1'b1) begin
      n_err++;
      $display("FAIL overlap_pixel: got hit=%b pix=%h want 1 FFF", hit, pix);
    end
`ifdef SPRITE_COLLISION_EN
    n_vec++;
    if (coll !== 1'b1) begin
      n_err++;
      $display("FAIL collision_set: got %b want 1", coll);
    end
`endif
    step(11'd212, 10'd92);
    step(11'd196, 10'd76);
    idle(4);
    commit_frame();
`ifdef SPRITE_COLLISION_EN
    n_vec++;
    if (coll !== 1'b0) begin
      n_err++;
      $display("FAIL collision_clear: got %b want 0", coll);
    end
`endif
    idle(4);
  endtask

  task automatic test_right_edge();
    cfg_write(2'd2, 11'd2040, 10'd10, 4'd1, 1'b1, 11'd40, 10'd3);
    commit_frame();
    for (int h = 2036; h < 2048; h++) step(11'(h), 10'd12);
    for (int h = 0; h < 10; h++) step(11'(h), 10'd12);
    idle(4);
  endtask

  task automatic test_commit_hold();
    step(11'(H_TOT - 1), 10'(V_TOT - 1));
    cfg_bus.cfg_idx_in   = 2'd3;
    cfg_bus.cfg_x_in     = 11'd300;
    cfg_bus.cfg_y_in     = 10'd100;
    cfg_bus.cfg_glyph_in = 4'd3;
    cfg_bus.cfg_en_in    = 1'b1;
    cfg_bus.cfg_valid_in = 1'b1;
    step(11'd0, 10'd0);
    step(11'd1, 10'd0);
    cfg_bus.cfg_valid_in = 1'b0;
    step(11'd300, 10'd100);
    idle(3);
    n_vec++;
    if (hit !== 1'b0) begin
      n_err++;
      $display("FAIL held_write_early: got hit=%b want 0", hit);
    end
    commit_frame();
    step(11'd305, 10'd110);
    idle(3);
    n_vec++;
    if (hit !== 1'b1) begin
      n_err++;
      $display("FAIL held_write_effective: got hit=%b want 1", hit);
    end
  endtask

  task automatic test_reset_mid();
    step(11'd2041, 10'd12);
    step(11'd2042, 10'd12);
    test_reset();
    step(11'd2041, 10'd12);
    step(11'd2043, 10'd13);
    idle(3);
    commit_frame();
    step(11'd2041, 10'd12);
    step(11'd305, 10'd110);
    idle(4);
  endtask

  initial begin
    cfg_bus.cfg_valid_in = 1'b0;
    cfg_bus.cfg_idx_in   = 2'd0;
    cfg_bus.cfg_x_in     = 11'd0;
    cfg_bus.cfg_y_in     = 10'd0;
    cfg_bus.cfg_glyph_in = 4'd0;
    cfg_bus.cfg_en_in    = 1'b0;
    test_reset();
    test_blank_frame();
    test_single_sprite();
    test_overlap();
    test_right_edge();
    test_commit_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
